// File: rtl/dec_3_8_pulse.sv
// dec_3_8_pulse
// Sequential 3-to-8 active-low pulse decoder. It is the inverse of the
// 8-to-3 active-low priority encoder. A 4-bit code {valid, idx[2:0]} is
// accepted over a valid/ready handshake. For an accepted code with valid=1,
// line idx is driven low for PULSE_LEN cycles, followed by one all-high gap
// cycle.
//
// Optional feature (macro DEC_PULSE_CNT_EN): when defined, the block adds the
// pulse_cnt output, a 16-bit wrapping count of accepted pulse codes.
//
// Parameters:
//   PULSE_LEN   number of cycles the selected line is held low (1..256).
//               A value of 0 behaves as 1.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   code_valid  a code is present this cycle
//   code[3:0]   code[3]=1: pulse line code[2:0]; code[3]=0: release code
//               (consumed, no output)
//   code_ready  the block can accept a code this cycle (combinational)
//   line_n[7:0] registered active-low decoded lines; idle value 8'hFF
//   busy        registered; high while a pulse or its gap cycle is in progress
//   pulse_cnt   (DEC_PULSE_CNT_EN only) count of accepted pulse codes
module dec_3_8_pulse #(
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       code_valid,
  input  logic [3:0] code,
  output logic       code_ready,
  output logic [7:0] line_n,
  output logic       busy
`ifdef DEC_PULSE_CNT_EN
  ,
  output logic [15:0] pulse_cnt
`endif
);

  // Clamp into the 1..256 range the 8-bit down-counter can represent.
  localparam int LEN_EFF = (PULSE_LEN < 1)   ? 1 :
                           (PULSE_LEN > 256) ? 256 : PULSE_LEN;
  // The first low cycle is spent in the same cycle the count is loaded.
  // So the counter starts at LEN-1 and the pulse ends when the count reads zero.
  localparam logic [7:0] COUNT_LOAD = 8'(LEN_EFF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] line_n_reg, line_n_next;
  logic       busy_reg, busy_next;

  logic       xfer;
  logic       xfer_pulse;
  logic [2:0] dec_idx;
  logic [7:0] dec_line;

  assign code_ready = (state_reg == IDLE) & reset_n;
  assign xfer       = code_valid & code_ready;
  assign xfer_pulse = xfer & code[3];

  // In IDLE, decode the incoming index, so the line goes low at the accepting
  // edge. After that, decode the latched index.
  assign dec_idx = (state_reg == IDLE) ? code[2:0] : idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign dec_line[gi] = (dec_idx != 3'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    line_n_next = line_n_reg;
    busy_next   = busy_reg;
    case (state_reg)
      IDLE: begin
        // A release code (code[3]=0) is accepted but leaves everything as is.
        if (xfer_pulse) begin
          idx_next    = code[2:0];
          count_next  = COUNT_LOAD;
          line_n_next = dec_line;
          busy_next   = 1'b1;
          state_next  = PULSE;
        end
      end
      PULSE: begin
        if (count_reg != 8'd0) begin
          count_next  = count_reg - 8'd1;
          line_n_next = dec_line;
        end else begin
          line_n_next = 8'hFF;
          state_next  = GAP;
        end
      end
      GAP: begin
        line_n_next = 8'hFF;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end
      default: begin
        line_n_next = 8'hFF;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= 8'd0;
      idx_reg    <= 3'd0;
      line_n_reg <= 8'hFF;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
      line_n_reg <= line_n_next;
      busy_reg   <= busy_next;
    end
  end

  assign line_n = line_n_reg;
  assign busy   = busy_reg;

`ifdef DEC_PULSE_CNT_EN
  logic [15:0] pulse_cnt_reg;

  // The count wraps naturally from 16'hFFFF to 16'h0000.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt_reg <= 16'd0;
    end else if (xfer_pulse) begin
      pulse_cnt_reg <= pulse_cnt_reg + 16'd1;
    end
  end

  assign pulse_cnt = pulse_cnt_reg;
`endif

endmodule

// File: doc/dec_3_8_pulse.md
Name: dec_3_8_pulse

Overview:
- Sequential inverse of the team's 8-to-3 active-low priority encoder.
- Accepts a 4-bit code `{valid, idx[2:0]}` over a valid/ready handshake and drives the selected active-low line of an 8-bit bus low for a programmable number of cycles.
- A mandatory all-high gap cycle follows every pulse.
- Sits downstream of the encoder, or any source using the same code format, to regenerate strobe lines.

Parameters:
- PULSE_LEN, 4, cycles the selected line is held low; legal 1..256. A value of 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- code_valid  input  1  code present this cycle
- code  input  4  code[3]=1: drive line code[2:0] low; code[3]=0: no line (release code)
- code_ready  output  1  block can accept a code this cycle
- line_n  output  8  registered active-low decoded lines; idle value 8'hFF
- busy  output  1  high in PULSE or GAP

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, line_n=8'hFF, internal count=0, latched index=0, busy=0.
  - code_ready=0 while reset_n=0.
  - Applies immediately, including mid-pulse; the line returns high without waiting for a clock.
- Code mapping (matches the encoder):
  - 4'b1111 -> line_n=8'b0111_1111 (line 7 low).
  - 4'b1000 -> line_n=8'b1111_1110 (line 0 low).
  - General rule: index i pulls line_n[i] low, all other lines high.
- code_ready is combinational: `(state==IDLE) & reset_n`. Transfer occurs on a rising edge with code_valid & code_ready.
- FSM, 3 states:
  - IDLE:
    - Transfer with code[3]=1: latch idx, load count=PULSE_LEN-1, set line_n to the decoded pattern at that same edge, go to PULSE.
    - Transfer with code[3]=0: consumed, no output change, stay in IDLE.
    - No transfer: stay in IDLE.
  - PULSE:
    - If count!=0: count decrements, line_n held.
    - If count==0: go to GAP, line_n=8'hFF.
    - code_valid is ignored (code_ready=0).
  - GAP: line_n=8'hFF. Always go to IDLE after exactly one cycle.
- Timing, with the transfer at edge N:
  - line_n low from after edge N through edge N+PULSE_LEN.
  - Exactly PULSE_LEN cycles low.
  - GAP lasts 1 cycle.
  - code_ready returns high after edge N+PULSE_LEN+1.
  - Earliest next transfer is edge N+PULSE_LEN+2. Back-to-back period is PULSE_LEN+2 cycles.
- PULSE_LEN=1: one low cycle, then GAP, then IDLE.
- PULSE_LEN=256: count is 8 bits and is loaded with 255.
- busy=1 in PULSE and GAP, 0 in IDLE. Registered with state.
- At most one line is ever low. Line values other than 8'hFF and one-hot-low are illegal; an assertion is required in the bench.
- code bits are don't-care when code_valid=0 or code_ready=0.

Optional Feature:
- Macro: DEC_PULSE_CNT_EN.
- When defined:
  - Adds output `pulse_cnt` [15:0].
  - Increments by 1 on every transfer with code[3]=1. Release codes do not increment it.
  - Wraps 16'hFFFF -> 16'h0000. Reset value 0 (async).
  - Updates at the same edge that line_n goes low.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release, no valid -> line_n=8'hFF, busy=0, code_ready=1.
- Single pulse, PULSE_LEN=4: send code=4'b1101 at edge N -> line_n=8'b1101_1111 for exactly 4 cycles, then 8'hFF, busy high for 5 cycles, next accept no earlier than edge N+6.
- All 8 indices back-to-back with code_valid held high -> line_n[i] low in order 0..7, each 4 cycles, each separated by one 8'hFF cycle; with DEC_PULSE_CNT_EN, pulse_cnt=8 at the end.
- Release code: code=4'b0101 in IDLE -> accepted, line_n stays 8'hFF, busy stays 0, pulse_cnt unchanged.
- Ignored during busy: present code=4'b1000 while in PULSE on line 3 -> line 3 pulse unaffected, line 0 never low until code_ready=1 and a new transfer occurs.
- Async reset mid-pulse: assert reset_n=0 two cycles into a line 7 pulse, between clock edges -> line_n=8'hFF immediately, code_ready=0; after release, state is IDLE with no residual pulse.
- Boundaries, with PULSE_LEN overridden:
  - PULSE_LEN=1 -> one low cycle per code.
  - PULSE_LEN=256 -> exactly 256 low cycles.
  - DEC_PULSE_CNT_EN with 65536 pulses -> pulse_cnt wraps to 0.
